glitch_sweep: RTL and testbench
===============================

GLITCH_SWEEP -- requirements
Module: glitch_sweep

Interface
REQ-001 SHALL have parameter POLL_GAP, default 4: idle cycles between successive STATUS polls (1..255).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16: cycles to wait for m_ack_i before aborting with an error.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port start_i, input, 1, one-cycle pulse that begins a sweep; ignored while busy_o=1.
REQ-006 SHALL have port abort_i, input, 1, level; stops the sweep at the next bus-idle point.
REQ-007 SHALL have ports delay_start_i, delay_end_i, input, 16 each, inclusive delay range; sampled on start.
REQ-008 SHALL have port delay_step_i, input, 8, delay increment; sampled on start.
REQ-009 SHALL have ports width_start_i, width_end_i, width_step_i, input, 8 each, inclusive width range and increment; sampled on start.
REQ-010 SHALL have port mode_i, input, 8, glitch mode written to GLITCH_MODE; sampled on start.
REQ-011 SHALL have Wishbone master ports m_adr_o out [5:2], m_dat_o out 8, m_dat_i in 8, m_stb_o out 1, m_we_o out 1, m_ack_i in 1, connecting to the glitch_wb slave.
REQ-012 SHALL have outputs busy_o 1, done_o 1 (one-cycle pulse), err_o 1 (sticky until next start), fire_o 1 (one-cycle pulse per armed attempt), cur_delay_o 16, cur_width_o 8.

Function
REQ-013 SHALL implement states IDLE, LOAD, WR_D0, WR_D1, WR_W, WR_MODE, ARM, GAP, POLL, NEXT, FIN.
REQ-014 IDLE->LOAD on start_i; LOAD latches all sweep inputs, sets cur_delay=delay_start, cur_width=width_start, clears err_o; busy_o=1 in every state except IDLE.
REQ-015 Bus cycle rule: m_stb_o asserts on state entry and holds, with stable adr/dat/we, until m_ack_i=1 is sampled; m_stb_o deasserts the following cycle; one transaction in flight at most.
REQ-016 WR_D0 writes cur_delay[7:0] to GLITCH_DELAY_0; WR_D1 writes cur_delay[15:8] to GLITCH_DELAY_1; WR_W writes cur_width to GLITCH_WIDTH; WR_MODE writes mode to GLITCH_MODE; ARM writes 8'h01 to GLITCH_STATUS and pulses fire_o on its ack.
REQ-017 WR_MODE executes only on the first attempt of a sweep; later attempts go WR_W->ARM.
REQ-018 After ARM: GAP waits POLL_GAP cycles, then POLL reads GLITCH_STATUS; on ack, m_dat_i[0]=1 ->NEXT, otherwise ->GAP.
REQ-019 NEXT, delay inner loop: next_delay = cur_delay + delay_step in 17 bits; if delay_step=0, or next_delay>delay_end, or bit16 set, then cur_delay=delay_start and width advances; else cur_delay=next_delay, ->WR_D0.
REQ-020 Width advance: next_width = cur_width + width_step in 9 bits; if width_step=0, or >width_end, or bit8 set, ->FIN; else cur_width=next_width, ->WR_D0.
REQ-021 start > end for either range: exactly one attempt at (start, start), then FIN.
REQ-022 FIN pulses done_o for one cycle, ->IDLE; cur_delay_o/cur_width_o hold the last armed values.
REQ-023 abort_i=1 sampled with no transaction in flight -> FIN, done_o pulses; if a transaction is in flight, wait for its ack first; an already-armed glitch is not cancelled.
REQ-024 No m_ack_i within ACK_TIMEOUT cycles of stb assertion -> drop stb, set err_o, ->FIN (done_o pulses).
REQ-025 start_i and abort_i in the same IDLE cycle: start wins; abort is then serviced per REQ-023.

Reset
REQ-026 rst_i=0 at a clock edge SHALL force IDLE, with m_stb_o=0, m_we_o=0, m_adr_o=0, m_dat_o=0, busy_o=0, done_o=0, err_o=0, fire_o=0, cur_delay_o=0, cur_width_o=0; mid-transaction reset drops stb the same edge.

Verification
REQ-027 delay 8..16 step 4, width 4..4, mode 0 -> writes D0=08,D1=00,W=04,MODE=00,STATUS=01, then D0=0C and D0=10 sweeps; 3 fire_o pulses, then done_o.
REQ-028 delay FFF8..FFFF step 8, width 2..6 step 2 -> bit16 overflow ends the delay loop; 3 attempts, delays FFF8 each, widths 2,4,6.
REQ-029 slave holds STATUS[0]=0 for 5 polls -> 5 POLL reads POLL_GAP+ cycles apart, no new writes until the ready read.
REQ-030 abort_i raised during GAP of attempt 2 of 6 -> done_o within 2 cycles, no further writes, fire_o count = 2.
REQ-031 m_ack_i held 0 on WR_D1 -> stb drops after 16 cycles, err_o=1, done_o pulse, busy_o=0.
REQ-032 rst_i=0 while m_stb_o=1 -> next edge all outputs at reset values; a new start_i then runs a full sweep normally.

Source files
------------

// File: rtl/glitch_sweep_if.sv
// Register bus between the glitch_sweep sequencer (master) and the glitch_wb slave.
// Single-beat Wishbone-style: stb held with stable adr/dat/we until ack.
interface glitch_sweep_if;
    logic [5:2] m_adr_o;
    logic [7:0] m_dat_o;
    logic [7:0] m_dat_i;
    logic       m_stb_o;
    logic       m_we_o;
    logic       m_ack_i;

    modport master (output m_adr_o, m_dat_o, m_stb_o, m_we_o, input m_dat_i, m_ack_i);
    modport slave  (input m_adr_o, m_dat_o, m_stb_o, m_we_o, output m_dat_i, m_ack_i);
endinterface

// File: rtl/glitch_sweep.sv
// Sweeps glitch delay (inner loop) and width (outer loop), programming and arming the
// glitch_wb slave once per point and polling STATUS until it reports the attempt finished.
module glitch_sweep #(
    parameter int POLL_GAP    = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [15:0]    delay_start_i,
    input  logic [15:0]    delay_end_i,
    input  logic [7:0]     delay_step_i,
    input  logic [7:0]     width_start_i,
    input  logic [7:0]     width_end_i,
    input  logic [7:0]     width_step_i,
    input  logic [7:0]     mode_i,
    glitch_sweep_if.master wb,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o,
    output logic           fire_o,
    output logic [15:0]    cur_delay_o,
    output logic [7:0]     cur_width_o
);

    // glitch_wb register map (word addresses)
    localparam logic [3:0] A_DLY0 = 4'h0;
    localparam logic [3:0] A_DLY1 = 4'h1;
    localparam logic [3:0] A_WID  = 4'h2;
    localparam logic [3:0] A_MODE = 4'h3;
    localparam logic [3:0] A_STAT = 4'h4;

    typedef enum logic [3:0] {
        IDLE, LOAD, WR_D0, WR_D1, WR_W, WR_MODE, ARM, GAP, POLL, NEXT, FIN
    } state_e;

    state_e      state_q, state_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [3:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        fire_q, fire_d;
    logic        first_q, first_d;
    logic [15:0] cur_delay_q, cur_delay_d;
    logic [7:0]  cur_width_q, cur_width_d;
    logic [15:0] arm_delay_q, arm_delay_d;
    logic [7:0]  arm_width_q, arm_width_d;

    logic [15:0] dly_start_q, dly_end_q;
    logic [7:0]  dly_step_q, wid_start_q, wid_end_q, wid_step_q, mode_q;
    logic        one_shot_q;

    logic [16:0] nxt_delay;
    logic [8:0]  nxt_width;
    logic        dly_wrap, wid_done;

    assign nxt_delay = {1'b0, cur_delay_q} + {9'd0, dly_step_q};
    assign nxt_width = {1'b0, cur_width_q} + {1'b0, wid_step_q};
    assign dly_wrap  = (dly_step_q == 8'd0) || nxt_delay[16] || (nxt_delay[15:0] > dly_end_q);
    assign wid_done  = (wid_step_q == 8'd0) || nxt_width[8]  || (nxt_width[7:0] > wid_end_q);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            dly_start_q <= '0;
            dly_end_q   <= '0;
            dly_step_q  <= '0;
            wid_start_q <= '0;
            wid_end_q   <= '0;
            wid_step_q  <= '0;
            mode_q      <= '0;
            one_shot_q  <= 1'b0;
        end else if (state_q == IDLE && start_i) begin
            dly_start_q <= delay_start_i;
            dly_end_q   <= delay_end_i;
            dly_step_q  <= delay_step_i;
            wid_start_q <= width_start_i;
            wid_end_q   <= width_end_i;
            wid_step_q  <= width_step_i;
            mode_q      <= mode_i;
            // an inverted range yields a single attempt at (start, start)
            one_shot_q  <= (delay_start_i > delay_end_i) || (width_start_i > width_end_i);
        end
    end

    always_comb begin
        state_d     = state_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        fire_d      = 1'b0;
        first_d     = first_q;
        cur_delay_d = cur_delay_q;
        cur_width_d = cur_width_q;
        arm_delay_d = arm_delay_q;
        arm_width_d = arm_width_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = LOAD;
                    err_d       = 1'b0;
                    first_d     = 1'b1;
                    cur_delay_d = delay_start_i;
                    cur_width_d = width_start_i;
                end
            end
            LOAD: state_d = abort_i ? FIN : WR_D0;
            WR_D0, WR_D1, WR_W, WR_MODE, ARM, POLL: begin
                if (!stb_q) begin
                    // stb low here means this state's access is not yet issued
                    if (abort_i) begin
                        state_d = FIN;
                    end else begin
                        stb_d = 1'b1;
                        cnt_d = '0;
                        we_d  = 1'b1;
                        case (state_q)
                            WR_D0:   begin adr_d = A_DLY0; dat_d = cur_delay_q[7:0];  end
                            WR_D1:   begin adr_d = A_DLY1; dat_d = cur_delay_q[15:8]; end
                            WR_W:    begin adr_d = A_WID;  dat_d = cur_width_q;       end
                            WR_MODE: begin adr_d = A_MODE; dat_d = mode_q;            end
                            ARM:     begin adr_d = A_STAT; dat_d = 8'h01;             end
                            default: begin adr_d = A_STAT; dat_d = 8'h00; we_d = 1'b0; end
                        endcase
                    end
                end else if (wb.m_ack_i) begin
                    stb_d = 1'b0;
                    cnt_d = '0;
                    case (state_q)
                        WR_D0:   state_d = WR_D1;
                        WR_D1:   state_d = WR_W;
                        WR_W:    state_d = first_q ? WR_MODE : ARM;
                        WR_MODE: begin
                            state_d = ARM;
                            first_d = 1'b0;
                        end
                        ARM: begin
                            state_d     = GAP;
                            fire_d      = 1'b1;
                            arm_delay_d = cur_delay_q;
                            arm_width_d = cur_width_q;
                        end
                        default: state_d = wb.m_dat_i[0] ? NEXT : GAP;
                    endcase
                    if (abort_i) state_d = FIN;
                end else if (cnt_q == 16'(ACK_TIMEOUT - 1)) begin
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (abort_i) begin
                    state_d = FIN;
                end else if (cnt_q == 16'(POLL_GAP - 1)) begin
                    state_d = POLL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            NEXT: begin
                if (abort_i || one_shot_q) begin
                    state_d = FIN;
                end else if (!dly_wrap) begin
                    cur_delay_d = nxt_delay[15:0];
                    state_d     = WR_D0;
                end else if (!wid_done) begin
                    cur_delay_d = dly_start_q;
                    cur_width_d = nxt_width[7:0];
                    state_d     = WR_D0;
                end else begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            fire_q      <= 1'b0;
            first_q     <= 1'b0;
            cur_delay_q <= '0;
            cur_width_q <= '0;
            arm_delay_q <= '0;
            arm_width_q <= '0;
        end else begin
            state_q     <= state_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            fire_q      <= fire_d;
            first_q     <= first_d;
            cur_delay_q <= cur_delay_d;
            cur_width_q <= cur_width_d;
            arm_delay_q <= arm_delay_d;
            arm_width_q <= arm_width_d;
        end
    end

    assign wb.m_stb_o  = stb_q;
    assign wb.m_we_o   = we_q;
    assign wb.m_adr_o  = adr_q;
    assign wb.m_dat_o  = dat_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == FIN);
    assign err_o       = err_q;
    assign fire_o      = fire_q;
    assign cur_delay_o = arm_delay_q;
    assign cur_width_o = arm_width_q;

endmodule

// File: tb/tb_glitch_sweep.sv
// Directed bench for glitch_sweep: a behavioural glitch_wb slave logs writes and
// answers STATUS polls; each scenario is checked against hand-built write lists.
module tb_glitch_sweep;
    localparam int POLL_GAP    = 4;
    localparam int ACK_TIMEOUT = 16;
    localparam logic [3:0] A_D0 = 4'h0, A_D1 = 4'h1, A_W = 4'h2, A_MODE = 4'h3, A_ST = 4'h4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0, start_i = 1'b0, abort_i = 1'b0;
    logic [15:0] delay_start = '0, delay_end = '0;
    logic [7:0]  delay_step = '0, width_start = '0, width_end = '0, width_step = '0, mode = '0;
    logic        busy_o, done_o, err_o, fire_o;
    logic [15:0] cur_delay_o;
    logic [7:0]  cur_width_o;

    glitch_sweep_if bus();

    glitch_sweep #(.POLL_GAP(POLL_GAP), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .delay_start_i(delay_start), .delay_end_i(delay_end), .delay_step_i(delay_step),
        .width_start_i(width_start), .width_end_i(width_end), .width_step_i(width_step),
        .mode_i(mode), .wb(bus.master),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .fire_o(fire_o),
        .cur_delay_o(cur_delay_o), .cur_width_o(cur_width_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, fire_n = 0, done_n = 0, poll_n = 0, d1_hi = 0;
    logic [11:0] wlog[$];
    int          ptimes[$];
    logic [11:0] expq[$];
    // slave controls, written only by the main sequence
    logic        sup_en = 1'b0;
    logic [3:0]  sup_adr = 4'h0;
    int          ready_hold = 0, poll_base = 0;

    always @(posedge clk) cyc++;

    // behavioural slave plus output monitors, all sampled mid-cycle
    always @(negedge clk) begin
        if (fire_o) fire_n++;
        if (done_o) done_n++;
        if (bus.m_stb_o && bus.m_adr_o == A_D1) d1_hi++;
        if (bus.m_stb_o && bus.m_ack_i !== 1'b1 && !(sup_en && bus.m_adr_o == sup_adr)) begin
            bus.m_ack_i = 1'b1;
            if (bus.m_we_o) begin
                wlog.push_back({bus.m_adr_o, bus.m_dat_o});
                bus.m_dat_i = 8'h00;
            end else begin
                bus.m_dat_i = {7'd0, (poll_n - poll_base) >= ready_hold};
                ptimes.push_back(cyc);
                poll_n++;
            end
        end else begin
            bus.m_ack_i = 1'b0;
            bus.m_dat_i = 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_sweep(input logic [15:0] ds, input logic [15:0] de, input logic [7:0] dst,
                               input logic [7:0] ws, input logic [7:0] we, input logic [7:0] wst,
                               input logic [7:0] md);
        delay_start = ds; delay_end = de; delay_step = dst;
        width_start = ws; width_end = we; width_step = wst; mode = md;
        start_i = 1'b1;
        @(negedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy_o && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_idle"}, busy_o, 1'b0);
    endtask

    // expected write list of one attempt
    task automatic exp_att(input logic [15:0] d, input logic [7:0] w, input bit first, input logic [7:0] md);
        expq.push_back({A_D0, d[7:0]});
        expq.push_back({A_D1, d[15:8]});
        expq.push_back({A_W, w});
        if (first) expq.push_back({A_MODE, md});
        expq.push_back({A_ST, 8'h01});
    endtask

    task automatic cmp_log(input string tag, input int base);
        chk({tag, "_nwr"}, wlog.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), (base + i < wlog.size()) ? wlog[base + i] : 12'hFFF, expq[i]);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_stb"},  bus.m_stb_o, 1'b0);
        chk({tag, "_we"},   bus.m_we_o, 1'b0);
        chk({tag, "_adr"},  bus.m_adr_o, 4'h0);
        chk({tag, "_dat"},  bus.m_dat_o, 8'h00);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_err"},  err_o, 1'b0);
        chk({tag, "_fire"}, fire_o, 1'b0);
        chk({tag, "_cdly"}, cur_delay_o, 16'h0);
        chk({tag, "_cwid"}, cur_width_o, 8'h0);
    endtask

    initial begin
        int w0, f0, d0, p0, h0, n;
        bit ok;

        repeat (3) @(negedge clk);
        #1 chk_reset("rst");
        rst_i = 1'b1;
        @(negedge clk); #1;

        // delay 8..16 step 4, single width
        expq.delete(); w0 = wlog.size(); f0 = fire_n; d0 = done_n;
        start_sweep(16'h0008, 16'h0010, 8'd4, 8'd4, 8'd4, 8'd1, 8'h00);
        chk("t1_busy", busy_o, 1'b1);
        wait_idle("t1", 2000);
        exp_att(16'h0008, 8'd4, 1, 8'h00); exp_att(16'h000C, 8'd4, 0, 8'h00); exp_att(16'h0010, 8'd4, 0, 8'h00);
        cmp_log("t1", w0);
        chk("t1_fire", fire_n - f0, 3);
        chk("t1_done", done_n - d0, 1);
        chk("t1_err",  err_o, 1'b0);
        chk("t1_cdly", cur_delay_o, 16'h0010);
        chk("t1_cwid", cur_width_o, 8'd4);

        // 17-bit delay overflow ends the inner loop; widths 2,4,6
        expq.delete(); w0 = wlog.size(); f0 = fire_n; d0 = done_n;
        start_sweep(16'hFFF8, 16'hFFFF, 8'd8, 8'd2, 8'd6, 8'd2, 8'h5A);
        wait_idle("t2", 2000);
        exp_att(16'hFFF8, 8'd2, 1, 8'h5A); exp_att(16'hFFF8, 8'd4, 0, 8'h5A); exp_att(16'hFFF8, 8'd6, 0, 8'h5A);
        cmp_log("t2", w0);
        chk("t2_fire", fire_n - f0, 3);
        chk("t2_done", done_n - d0, 1);
        chk("t2_cdly", cur_delay_o, 16'hFFF8);
        chk("t2_cwid", cur_width_o, 8'd6);

        // slave reports not-ready for 5 polls
        expq.delete(); w0 = wlog.size(); p0 = ptimes.size();
        poll_base = poll_n; ready_hold = 5;
        start_sweep(16'h0005, 16'h0005, 8'd1, 8'd1, 8'd1, 8'd1, 8'h33);
        wait_idle("t3", 2000);
        ready_hold = 0;
        exp_att(16'h0005, 8'd1, 1, 8'h33);
        cmp_log("t3", w0);
        chk("t3_npoll", ptimes.size() - p0, 6);
        ok = 1'b1;
        for (int i = p0 + 1; i < ptimes.size(); i++)
            if (ptimes[i] - ptimes[i-1] < POLL_GAP + 1) ok = 1'b0;
        chk("t3_pgap", ok, 1'b1);

        // abort during GAP of the second of six attempts
        expq.delete(); w0 = wlog.size(); f0 = fire_n; d0 = done_n;
        start_sweep(16'h0000, 16'h0005, 8'd1, 8'd7, 8'd7, 8'd1, 8'h03);
        n = 0;
        while (fire_n - f0 < 2 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("t4_fire2", fire_n - f0, 2);
        abort_i = 1'b1;
        n = 0;
        while (!done_o && n < 3) begin
            @(negedge clk); #1;
            n++;
        end
        chk("t4_abort_lat", done_o && n <= 2, 1'b1);
        wait_idle("t4", 50);
        abort_i = 1'b0;
        exp_att(16'h0000, 8'd7, 1, 8'h03); exp_att(16'h0001, 8'd7, 0, 8'h03);
        cmp_log("t4", w0);
        chk("t4_fire", fire_n - f0, 2);
        chk("t4_done", done_n - d0, 1);

        // inverted delay range: one attempt at the start values
        expq.delete(); w0 = wlog.size(); f0 = fire_n;
        start_sweep(16'h000A, 16'h0005, 8'd1, 8'd3, 8'd7, 8'd1, 8'h11);
        wait_idle("t5", 2000);
        exp_att(16'h000A, 8'd3, 1, 8'h11);
        cmp_log("t5", w0);
        chk("t5_fire", fire_n - f0, 1);
        chk("t5_cdly", cur_delay_o, 16'h000A);
        chk("t5_cwid", cur_width_o, 8'd3);

        // no ack on DELAY_1 write
        expq.delete(); w0 = wlog.size(); f0 = fire_n; d0 = done_n; h0 = d1_hi;
        sup_en = 1'b1; sup_adr = A_D1;
        start_sweep(16'h1234, 16'h1234, 8'd1, 8'd1, 8'd1, 8'd1, 8'h00);
        wait_idle("t6", 200);
        sup_en = 1'b0;
        expq.push_back({A_D0, 8'h34});
        cmp_log("t6", w0);
        chk("t6_stbhi", d1_hi - h0, ACK_TIMEOUT);
        chk("t6_err",  err_o, 1'b1);
        chk("t6_done", done_n - d0, 1);
        chk("t6_fire", fire_n - f0, 0);
        start_sweep(16'h0002, 16'h0001, 8'd1, 8'd1, 8'd1, 8'd1, 8'h00);
        chk("t6_errclr", err_o, 1'b0);
        wait_idle("t6b", 2000);

        // start and abort in the same idle cycle
        w0 = wlog.size(); f0 = fire_n; d0 = done_n;
        abort_i = 1'b1;
        start_sweep(16'h0000, 16'h0004, 8'd1, 8'd1, 8'd1, 8'd1, 8'h00);
        chk("t7_busy", busy_o, 1'b1);
        wait_idle("t7", 50);
        abort_i = 1'b0;
        chk("t7_nwr",  wlog.size() - w0, 0);
        chk("t7_done", done_n - d0, 1);
        chk("t7_fire", fire_n - f0, 0);

        // reset with stb asserted, then a full sweep
        start_sweep(16'h0008, 16'h0010, 8'd4, 8'd4, 8'd4, 8'd1, 8'h00);
        n = 0;
        while (!bus.m_stb_o && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("t8_stb_seen", bus.m_stb_o, 1'b1);
        rst_i = 1'b0;
        @(negedge clk); #1;
        chk_reset("t8rst");
        rst_i = 1'b1;
        @(negedge clk); #1;
        expq.delete(); w0 = wlog.size(); f0 = fire_n; d0 = done_n;
        start_sweep(16'h0008, 16'h0010, 8'd4, 8'd4, 8'd4, 8'd1, 8'h00);
        wait_idle("t8", 2000);
        exp_att(16'h0008, 8'd4, 1, 8'h00); exp_att(16'h000C, 8'd4, 0, 8'h00); exp_att(16'h0010, 8'd4, 0, 8'h00);
        cmp_log("t8", w0);
        chk("t8_fire", fire_n - f0, 3);
        chk("t8_done", done_n - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
